// File: rtl/memory_arbiter_pkg.sv
// Shared types and width constants for the MERC-16 fetch/data memory arbiter.
package memory_arbiter_pkg;

    localparam int unsigned ADDR_W   = 16;
    localparam int unsigned DATA_W   = 16;
    localparam int unsigned STREAK_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE
    } arb_state_e;

    typedef enum logic {
        SEL_FETCH,
        SEL_DATA
    } arb_sel_e;

endpackage

// File: rtl/arb_priority_select.sv
// Winner selection for the memory arbiter: data priority with a fetch anti-starvation
// streak counter.
module arb_priority_select
    import memory_arbiter_pkg::*;
#(
    parameter int unsigned DATA_STREAK_MAX = 4
) (
    input  logic     Clock,
    input  logic     Reset,
    input  logic     arb_en,
    input  logic     fetch_req,
    input  logic     data_req,
    output arb_sel_e sel
);

    localparam logic [STREAK_W-1:0] StreakMax = STREAK_W'(DATA_STREAK_MAX);

    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                grant;

    assign grant = arb_en & (fetch_req | data_req);

    always_comb begin
        sel = SEL_FETCH;
        if (data_req && !(fetch_req && (streak_q == StreakMax))) begin
            sel = SEL_DATA;
        end
    end

    // Only data grants made while fetch is waiting count towards the streak.
    always_comb begin
        streak_d = streak_q;
        if (grant && (sel == SEL_FETCH)) begin
            streak_d = '0;
        end else if (arb_en && !fetch_req) begin
            streak_d = '0;
        end else if (grant) begin
            streak_d = streak_q + 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// Fetch/data arbiter and sequencer for the single-port MemorySubsystem.
// Define MEM_ARB_ALIGN_CHECK_EN to fault odd addresses instead of passing them through.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int unsigned DATA_STREAK_MAX = 4,
    parameter int unsigned ADDR_WIDTH      = ADDR_W,
    parameter int unsigned DATA_WIDTH      = DATA_W
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  FetchReq,
    input  logic [ADDR_WIDTH-1:0] FetchAddr,
    output logic                  FetchAck,
    output logic [DATA_WIDTH-1:0] FetchData,
    output logic                  FetchFault,
    input  logic                  DataReq,
    input  logic                  DataWrite,
    input  logic [ADDR_WIDTH-1:0] DataAddr,
    input  logic [DATA_WIDTH-1:0] DataWData,
    output logic                  DataAck,
    output logic [DATA_WIDTH-1:0] DataRData,
    output logic                  DataFault,
    output logic [ADDR_WIDTH-1:0] MemByteAddress,
    output logic [DATA_WIDTH-1:0] MemDIN,
    output logic                  MemWriteEnable,
    input  logic [DATA_WIDTH-1:0] MemDOUT,
    output logic                  Busy
);

    arb_state_e            state_q, state_d;
    arb_sel_e              sel, sel_q, sel_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d, win_addr;
    logic [DATA_WIDTH-1:0] din_q, din_d, rdata;
    logic                  we_q, we_d, fault_q, fault_d, win_fault;
    logic                  f_ack_q, f_ack_d, d_ack_q, d_ack_d;
    logic [DATA_WIDTH-1:0] f_data_q, f_data_d, d_data_q, d_data_d;
    logic                  f_fault_q, f_fault_d, d_fault_q, d_fault_d;

    arb_priority_select #(
        .DATA_STREAK_MAX(DATA_STREAK_MAX)
    ) u_priority (
        .Clock    (Clock),
        .Reset    (Reset),
        .arb_en   (state_q == IDLE),
        .fetch_req(FetchReq),
        .data_req (DataReq),
        .sel      (sel)
    );

    assign win_addr = (sel == SEL_DATA) ? DataAddr : FetchAddr;

`ifdef MEM_ARB_ALIGN_CHECK_EN
    assign win_fault = win_addr[0];
`else
    assign win_fault = 1'b0;
`endif

    assign rdata = fault_q ? '0 : MemDOUT;

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        addr_d    = addr_q;
        din_d     = din_q;
        we_d      = 1'b0;
        fault_d   = fault_q;
        f_ack_d   = 1'b0;
        d_ack_d   = 1'b0;
        f_data_d  = f_data_q;
        d_data_d  = d_data_q;
        f_fault_d = f_fault_q;
        d_fault_d = d_fault_q;
        unique case (state_q)
            IDLE: begin
                if (FetchReq || DataReq) begin
                    sel_d   = sel;
                    addr_d  = win_addr;
                    din_d   = (sel == SEL_DATA) ? DataWData : '0;
                    we_d    = (sel == SEL_DATA) && DataWrite && !win_fault;
                    fault_d = win_fault;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                if (sel_q == SEL_DATA) begin
                    d_ack_d   = 1'b1;
                    d_data_d  = rdata;
                    d_fault_d = fault_q;
                end else begin
                    f_ack_d   = 1'b1;
                    f_data_d  = rdata;
                    f_fault_d = fault_q;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= IDLE;
            sel_q     <= SEL_FETCH;
            addr_q    <= '0;
            din_q     <= '0;
            we_q      <= 1'b0;
            fault_q   <= 1'b0;
            f_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            f_data_q  <= '0;
            d_data_q  <= '0;
            f_fault_q <= 1'b0;
            d_fault_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            addr_q    <= addr_d;
            din_q     <= din_d;
            we_q      <= we_d;
            fault_q   <= fault_d;
            f_ack_q   <= f_ack_d;
            d_ack_q   <= d_ack_d;
            f_data_q  <= f_data_d;
            d_data_q  <= d_data_d;
            f_fault_q <= f_fault_d;
            d_fault_q <= d_fault_d;
        end
    end

    assign FetchAck       = f_ack_q;
    assign FetchData      = f_data_q;
    assign FetchFault     = f_fault_q;
    assign DataAck        = d_ack_q;
    assign DataRData      = d_data_q;
    assign DataFault      = d_fault_q;
    assign MemByteAddress = addr_q;
    assign MemDIN         = din_q;
    assign MemWriteEnable = we_q;
    assign Busy           = (state_q != IDLE);

endmodule
